// File: rtl/ppl_event_monitor.sv
// ppl_event_monitor
//
// Windowed event-monitor bank for the hardware-scheduler interface. Each of NUM_EVENTS
// channels counts single-cycle event pulses with saturating arithmetic over a window of
// WINDOW_CYCLES clock cycles. At the end of a window the totals are copied into held
// snapshot registers, and a threshold-based swap hint is raised. The consumer acknowledges
// a snapshot with snap_ack_i. A window that ends while an unacknowledged snapshot is still
// pending sets the sticky overrun flag, and the old snapshot is kept.
//
// Optional feature: define EVENT_MON_RETIRE_EN to build a retire counter on commit_valid_i.
// This counter follows the same window, clear and sched_swap rules as the event channels.
// Its window total is snapshotted into snap_retire_o, and an empty window (zero retires)
// suppresses swap_hint_o. When the macro is undefined, snap_retire_o is tied to 0 and
// commit_valid_i is ignored.
//
// Ports
//   clk_i          clock
//   rst_i          synchronous active-high reset
//   monitor_en_i   1 = counting, 0 = idle with running counters cleared
//   event_en_i     per-channel event pulse, sampled every cycle
//   commit_valid_i retire strobe (EVENT_MON_RETIRE_EN only)
//   sched_swap_i   scheduler swapped PCs; restarts the current window, no snapshot
//   threshold_i    per-channel swap threshold, channel i at [i*CNT_WIDTH +: CNT_WIDTH];
//                  0 disables that channel
//   snap_count_o   held snapshot of channel totals, same packing as threshold_i
//   snap_retire_o  held snapshot of retire total
//   snap_valid_o   snapshot available until the cycle after snap_ack_i
//   snap_ack_i     consumer accepts the snapshot
//   swap_hint_o    some enabled channel reached its threshold; qualified by snap_valid_o
//   overrun_o      sticky: a window ended while a snapshot was still pending
module ppl_event_monitor #(
  parameter int unsigned NUM_EVENTS    = 5,
  parameter int unsigned CNT_WIDTH     = 16,
  parameter int unsigned WINDOW_CYCLES = 1024
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             monitor_en_i,
  input  logic [NUM_EVENTS-1:0]            event_en_i,
  input  logic                             commit_valid_i,
  input  logic                             sched_swap_i,
  input  logic [NUM_EVENTS*CNT_WIDTH-1:0]  threshold_i,
  output logic [NUM_EVENTS*CNT_WIDTH-1:0]  snap_count_o,
  output logic [CNT_WIDTH-1:0]             snap_retire_o,
  output logic                             snap_valid_o,
  input  logic                             snap_ack_i,
  output logic                             swap_hint_o,
  output logic                             overrun_o
);

  localparam int unsigned           WinW    = $clog2(WINDOW_CYCLES);
  localparam logic [WinW-1:0]       WinLast = WinW'(WINDOW_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0]  CntMax  = '1;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e                                state_q;
  logic [NUM_EVENTS-1:0][CNT_WIDTH-1:0]  cnt_q;
  logic [NUM_EVENTS-1:0][CNT_WIDTH-1:0]  snap_q;
  logic [WinW-1:0]                       win_q;
  logic                                  snap_valid_q;
  logic                                  swap_hint_q;
  logic                                  overrun_q;

  logic [NUM_EVENTS-1:0][CNT_WIDTH-1:0]  total;
  logic                                  hint_raw;
  logic                                  hint_d;
  logic                                  in_run;
  logic                                  cnt_clear;
  logic                                  win_end;
  logic                                  snap_take;

  // Window control. Priority inside RUN: monitor disable, then sched_swap, then window end.
  assign in_run    = (state_q == StRun);
  assign win_end   = in_run && monitor_en_i && !sched_swap_i && (win_q == WinLast);
  assign cnt_clear = in_run && (!monitor_en_i || sched_swap_i || (win_q == WinLast));
  assign snap_take = win_end && (!snap_valid_q || snap_ack_i);

  // Saturating per-channel totals including this cycle's events, plus the raw hint.
  always_comb begin
    total    = cnt_q;
    hint_raw = 1'b0;
    for (int i = 0; i < int'(NUM_EVENTS); i++) begin
      if (cnt_q[i] != CntMax) begin
        total[i] = cnt_q[i] + CNT_WIDTH'(event_en_i[i]);
      end
      if ((threshold_i[i*CNT_WIDTH +: CNT_WIDTH] != '0) &&
          (total[i] >= threshold_i[i*CNT_WIDTH +: CNT_WIDTH])) begin
        hint_raw = 1'b1;
      end
    end
  end

`ifdef EVENT_MON_RETIRE_EN
  logic [CNT_WIDTH-1:0] ret_q;
  logic [CNT_WIDTH-1:0] ret_total;
  logic [CNT_WIDTH-1:0] snap_ret_q;

  assign ret_total = (ret_q == CntMax) ? ret_q : ret_q + CNT_WIDTH'(commit_valid_i);
  // A window with nothing retired carries no useful signal for the scheduler.
  assign hint_d    = hint_raw && (ret_total != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ret_q      <= '0;
      snap_ret_q <= '0;
    end else begin
      if (cnt_clear) begin
        ret_q <= '0;
      end else if (in_run) begin
        ret_q <= ret_total;
      end
      if (snap_take) begin
        snap_ret_q <= ret_total;
      end
    end
  end

  assign snap_retire_o = snap_ret_q;
`else
  logic unused_commit_valid;

  assign unused_commit_valid = commit_valid_i;
  assign hint_d              = hint_raw;
  assign snap_retire_o       = '0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      win_q        <= '0;
      snap_q       <= '0;
      snap_valid_q <= 1'b0;
      swap_hint_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle:  if (monitor_en_i) state_q <= StRun;
        StRun:   if (!monitor_en_i) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase

      if (cnt_clear) begin
        cnt_q <= '0;
        win_q <= '0;
      end else if (in_run) begin
        cnt_q <= total;
        win_q <= win_q + WinW'(1);
      end

      // overrun_q can only be set while a snapshot is pending, so a take (which needs
      // either no pending snapshot or an ack) always leaves it clear.
      if (snap_take) begin
        snap_q       <= total;
        snap_valid_q <= 1'b1;
        swap_hint_q  <= hint_d;
        overrun_q    <= 1'b0;
      end else if (win_end) begin
        overrun_q    <= 1'b1;
      end else if (snap_ack_i && snap_valid_q) begin
        snap_valid_q <= 1'b0;
        swap_hint_q  <= 1'b0;
        overrun_q    <= 1'b0;
      end
    end
  end

  assign snap_count_o = snap_q;
  assign snap_valid_o = snap_valid_q;
  assign swap_hint_o  = swap_hint_q;
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_ppl_event_monitor.sv
// Directed bench for ppl_event_monitor: 2 channels, 8-cycle window, 4-bit counters, plus a
// 3-bit-counter instance that runs alongside the main one to show saturation.
module tb_ppl_event_monitor;

  localparam int unsigned NE  = 2;
  localparam int unsigned CW  = 4;
  localparam int unsigned WIN = 8;
`ifdef EVENT_MON_RETIRE_EN
  localparam bit RetOn = 1'b1;
`else
  localparam bit RetOn = 1'b0;
`endif

  typedef struct {
    logic [3:0] c0;
    logic [3:0] c1;
    logic       hint;
    logic [3:0] ret;
    logic       ovr;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          monitor_en;
  logic [NE-1:0] event_en;
  logic          commit_valid;
  logic          sched_swap;
  logic          snap_ack;
  logic [3:0]    thr0;
  logic [3:0]    thr1;
  logic [NE*CW-1:0] threshold;
  logic [NE*CW-1:0] snap_count;
  logic [CW-1:0]    snap_retire;
  logic             snap_valid;
  logic             swap_hint;
  logic             overrun;
  logic [NE*3-1:0]  s_snap_count;
  logic [2:0]       s_snap_retire;
  logic             s_snap_valid;
  logic             s_swap_hint;
  logic             s_overrun;

  int   ncmp = 0;
  int   nfail = 0;
  logic model_valid;
  exp_t last_exp;
  exp_t sb_q[$];

  always #5 clk = ~clk;
  assign threshold = {thr1, thr0};

  ppl_event_monitor #(.NUM_EVENTS(NE), .CNT_WIDTH(CW), .WINDOW_CYCLES(WIN)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .monitor_en_i   (monitor_en),
    .event_en_i     (event_en),
    .commit_valid_i (commit_valid),
    .sched_swap_i   (sched_swap),
    .threshold_i    (threshold),
    .snap_count_o   (snap_count),
    .snap_retire_o  (snap_retire),
    .snap_valid_o   (snap_valid),
    .snap_ack_i     (snap_ack),
    .swap_hint_o    (swap_hint),
    .overrun_o      (overrun)
  );

  ppl_event_monitor #(.NUM_EVENTS(NE), .CNT_WIDTH(3), .WINDOW_CYCLES(WIN)) dut_s (
    .clk_i          (clk),
    .rst_i          (rst),
    .monitor_en_i   (monitor_en),
    .event_en_i     (event_en),
    .commit_valid_i (commit_valid),
    .sched_swap_i   (sched_swap),
    .threshold_i    ('0),
    .snap_count_o   (s_snap_count),
    .snap_retire_o  (s_snap_retire),
    .snap_valid_o   (s_snap_valid),
    .snap_ack_i     (snap_ack),
    .swap_hint_o    (s_swap_hint),
    .overrun_o      (s_overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] sat4(input int n);
    return (n > 15) ? 4'd15 : 4'(n);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_count"}, snap_count, 0);
    check({tag, "_retire"}, snap_retire, 0);
    check({tag, "_valid"}, snap_valid, 0);
    check({tag, "_hint"}, swap_hint, 0);
    check({tag, "_overrun"}, overrun, 0);
  endtask

  // One full window starting at win=0. Channel 0 fires in the first n0 cycles, channel 1 in
  // the first n1, commit in the first ncv. Pushes the expected snapshot unless sched_swap
  // aborts the window.
  task automatic win8(input int n0, input int n1, input int ncv, input bit ack_first,
                      input bit ack_last, input int swap_at, input string tag);
    logic vbe;
    exp_t e;
    vbe = model_valid && !ack_first;
    for (int k = 0; k < 8; k++) begin
      event_en     = {(k < n1), (k < n0)};
      commit_valid = (k < ncv);
      snap_ack     = (k == 0 && ack_first) || (k == 7 && ack_last);
      sched_swap   = (k == swap_at);
      cyc();
      if (k == 0 && ack_first) begin
        check({tag, "_ack_valid"}, snap_valid, 0);
        check({tag, "_ack_overrun"}, overrun, 0);
      end
      if (k == 6 && !vbe) check({tag, "_early_valid"}, snap_valid, 0);
    end
    event_en = '0; commit_valid = 0; snap_ack = 0; sched_swap = 0;
    if (swap_at >= 0) begin
      model_valid = vbe;
    end else if (!vbe || ack_last) begin
      e.c0   = sat4(n0);
      e.c1   = sat4(n1);
      e.ret  = RetOn ? sat4(ncv) : 4'd0;
      e.hint = ((thr0 != 0 && e.c0 >= thr0) || (thr1 != 0 && e.c1 >= thr1)) &&
               (!RetOn || ncv != 0);
      e.ovr  = 1'b0;
      model_valid = 1'b1;
      last_exp = e;
      sb_q.push_back(e);
    end else begin
      e = last_exp;
      e.ovr = 1'b1;
      last_exp = e;
      sb_q.push_back(e);
    end
  endtask

  task automatic check_snap(input string tag);
    exp_t e;
    check({tag, "_valid"}, snap_valid, 1);
    e = sb_q.pop_front();
    check({tag, "_count"}, snap_count, {e.c1, e.c0});
    check({tag, "_hint"}, swap_hint, e.hint);
    check({tag, "_retire"}, snap_retire, e.ret);
    check({tag, "_overrun"}, overrun, e.ovr);
  endtask

  initial begin
    rst = 1; monitor_en = 0; event_en = '0; commit_valid = 0; sched_swap = 0; snap_ack = 0;
    thr0 = 0; thr1 = 0; model_valid = 0;
    cyc();
    cyc();
    rst = 0;
    check_reset("reset");

    monitor_en = 1;
    cyc();

    win8(8, 0, 4, 0, 0, -1, "A");
    check_snap("A");
    check("sat_count", s_snap_count[2:0], 7);
    check("sat_valid", s_snap_valid, 1);

    thr1 = 5;
    win8(0, 5, 8, 1, 0, -1, "B");
    check_snap("B");
    thr1 = 6;
    win8(0, 5, 8, 1, 0, -1, "C");
    check_snap("C");
    thr1 = 0;
    win8(0, 8, 8, 1, 0, -1, "D");
    check_snap("D");

    // sched_swap on the last window cycle: no snapshot, next window restarts from zero.
    win8(3, 0, 5, 1, 0, 7, "H");
    check("H_nosnap", snap_valid, 0);
    win8(2, 0, 1, 0, 0, -1, "I");
    check_snap("I");

    // Partial window, then disable: counters clear, snapshot from I stays.
    event_en = 2'b11; commit_valid = 1;
    repeat (4) cyc();
    monitor_en = 0;
    cyc();
    repeat (3) cyc();
    check("idle_valid", snap_valid, 1);
    check("idle_count", snap_count, {4'd0, 4'd2});
    event_en = '0; commit_valid = 0; monitor_en = 1;
    cyc();
    win8(0, 3, 2, 1, 0, -1, "J");
    check_snap("J");

    // Ack coinciding with window end: new snapshot, no gap.
    win8(4, 1, 3, 0, 1, -1, "K");
    check_snap("K");

    // Over threshold but no retires: the retire counter, when built, suppresses the hint.
    thr1 = 5;
    win8(0, 8, 0, 1, 0, -1, "L");
    check_snap("L");
    // No ack: overrun, L retained.
    win8(1, 0, 1, 0, 0, -1, "M");
    check_snap("M");
    thr1 = 0;
    win8(0, 0, 0, 1, 0, -1, "N");
    check_snap("N");

    event_en = 2'b11;
    repeat (3) cyc();
    rst = 1;
    cyc();
    rst = 0;
    event_en = '0;
    check_reset("midrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
